// File: rtl/spectrum_frame_buffer_if.sv
// Bus between the peak finder / sample source and the spectrum frame buffer.
//   s_valid, s_sof, s_data : streaming sample input
//   rd, addr_in            : finder read request
//   pk_done                : finder window status (falling edge = window finished)
//   rdy, FreqOut           : frame-held flag and read data back to the finder
//   frame_drop, short_err  : single-cycle event pulses
//   ovf_cnt                : saturating frame_drop count
// master drives the inputs of the buffer; slave is the buffer itself.
interface spectrum_frame_buffer_if #(
    parameter int unsigned DW = 8
);
    logic          s_valid;
    logic          s_sof;
    logic [DW-1:0] s_data;
    logic          rd;
    logic [11:0]   addr_in;
    logic          pk_done;
    logic          rdy;
    logic [DW-1:0] FreqOut;
    logic          frame_drop;
    logic          short_err;
    logic [7:0]    ovf_cnt;

    modport master (
        output s_valid, s_sof, s_data, rd, addr_in, pk_done,
        input  rdy, FreqOut, frame_drop, short_err, ovf_cnt
    );

    modport slave (
        input  s_valid, s_sof, s_data, rd, addr_in, pk_done,
        output rdy, FreqOut, frame_drop, short_err, ovf_cnt
    );
endinterface

// File: rtl/spectrum_frame_buffer.sv
// Ping-pong sample memory for the adaptive peak finder.
// A write FSM captures sof-delimited frames into one of two banks; a read FSM
// presents the oldest full bank to the finder (rdy), serves reads with a
// two-cycle registered latency, and frees the bank after WINDOWS_PER_FRAME
// falling edges of pk_done.
// Ports: clk, rst (synchronous, active-high), bus (slave modport carrying the
// sample stream, finder read/status inputs and rdy/FreqOut/event outputs).
module spectrum_frame_buffer #(
    parameter int unsigned FRAME_LEN         = 512,
    parameter int unsigned WINDOWS_PER_FRAME = 3,
    parameter int unsigned DW                = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    spectrum_frame_buffer_if.slave bus
);
    localparam int unsigned AW        = 12;
    localparam int unsigned AWX       = AW + 1;
    localparam int unsigned MEM_DEPTH = 2 * FRAME_LEN;
    localparam int unsigned IW        = $clog2(MEM_DEPTH);
    localparam int unsigned WCW       = (WINDOWS_PER_FRAME > 1) ? $clog2(WINDOWS_PER_FRAME) : 1;

    localparam logic [AW-1:0]  LAST_PTR = AW'(FRAME_LEN - 1);
    localparam logic [AWX-1:0] LEN_EXT  = AWX'(FRAME_LEN);
    localparam logic [WCW-1:0] LAST_WIN = WCW'(WINDOWS_PER_FRAME - 1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic {R_IDLE, R_SERVE} r_state_t;

    // Flat memory index: bank 1 sits directly above bank 0.
    function automatic logic [IW-1:0] mem_idx(input logic bank, input logic [AW-1:0] ptr);
        logic [AWX-1:0] base;
        base = bank ? LEN_EXT : '0;
        return IW'(base + {1'b0, ptr});
    endfunction

    // Write side state
    w_state_t      w_state, w_state_nxt;
    logic [AW-1:0] wr_ptr, wr_ptr_nxt;
    logic          wr_bank, wr_bank_nxt;
    logic [1:0]    full, full_nxt;
    logic          first_full, first_full_nxt;
    logic          frame_drop_q, frame_drop_nxt;
    logic          short_err_q, short_err_nxt;
    logic [7:0]    ovf_cnt_q, ovf_cnt_nxt;
    logic          we_c, we_bank_c, done_c, sof_c;
    logic [AW-1:0] we_ptr_c;
    logic [1:0]    free_c;

    // Read side state
    r_state_t       r_state, r_state_nxt;
    logic           rd_bank, rd_bank_nxt;
    logic [WCW-1:0] win_cnt, win_cnt_nxt;
    logic           rdy_q, rdy_nxt;
    logic           pk_done_q;
    logic           release_c, pk_fall_c;

    // Read data path
    logic          rd_q, rd_q2, zero_q2;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] mem_q, freq_q;
    logic          in_range_c;
    logic [IW-1:0] rd_idx_c;

    logic [DW-1:0] mem [MEM_DEPTH];

    // Write FSM next-state
    always_comb begin
        w_state_nxt    = w_state;
        wr_ptr_nxt     = wr_ptr;
        wr_bank_nxt    = wr_bank;
        full_nxt       = full;
        first_full_nxt = first_full;
        frame_drop_nxt = 1'b0;
        short_err_nxt  = 1'b0;
        ovf_cnt_nxt    = ovf_cnt_q;
        we_c           = 1'b0;
        we_bank_c      = wr_bank;
        we_ptr_c       = wr_ptr;
        done_c         = 1'b0;
        sof_c          = bus.s_valid & bus.s_sof;

        // Release lands before the writer looks for a bank, so a bank freed
        // this cycle can be claimed by a same-cycle sof.
        if (release_c) begin
            full_nxt[rd_bank] = 1'b0;
            first_full_nxt    = !rd_bank;
        end
        free_c = ~full_nxt;

        case (w_state)
            W_IDLE, W_DROP: begin
                if (sof_c) begin
                    if (free_c != 2'b00) begin
                        we_c        = 1'b1;
                        we_bank_c   = !free_c[0];
                        we_ptr_c    = '0;
                        wr_bank_nxt = !free_c[0];
                        if (FRAME_LEN == 1) begin
                            done_c      = 1'b1;
                            w_state_nxt = W_IDLE;
                        end else begin
                            wr_ptr_nxt  = AW'(1);
                            w_state_nxt = W_FILL;
                        end
                    end else begin
                        frame_drop_nxt = 1'b1;
                        if (ovf_cnt_q != 8'hFF) ovf_cnt_nxt = ovf_cnt_q + 8'd1;
                        w_state_nxt = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (bus.s_valid) begin
                    we_c = 1'b1;
                    if (bus.s_sof) begin
                        // Early sof: throw away the partial frame, restart in place.
                        short_err_nxt = 1'b1;
                        we_ptr_c      = '0;
                        wr_ptr_nxt    = AW'(1);
                    end else if (wr_ptr == LAST_PTR) begin
                        done_c      = 1'b1;
                        wr_ptr_nxt  = '0;
                        w_state_nxt = W_IDLE;
                    end else begin
                        wr_ptr_nxt = wr_ptr + AW'(1);
                    end
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase

        // first_full tracks the older of the full banks.
        if (done_c) begin
            full_nxt[we_bank_c] = 1'b1;
            if (!full_nxt[!we_bank_c]) first_full_nxt = we_bank_c;
        end
    end

    // Write FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state      <= W_IDLE;
            wr_ptr       <= '0;
            wr_bank      <= 1'b0;
            full         <= '0;
            first_full   <= 1'b0;
            frame_drop_q <= 1'b0;
            short_err_q  <= 1'b0;
            ovf_cnt_q    <= '0;
        end else begin
            w_state      <= w_state_nxt;
            wr_ptr       <= wr_ptr_nxt;
            wr_bank      <= wr_bank_nxt;
            full         <= full_nxt;
            first_full   <= first_full_nxt;
            frame_drop_q <= frame_drop_nxt;
            short_err_q  <= short_err_nxt;
            ovf_cnt_q    <= ovf_cnt_nxt;
        end
    end

    // Read FSM next-state
    always_comb begin
        r_state_nxt = r_state;
        rd_bank_nxt = rd_bank;
        win_cnt_nxt = win_cnt;
        rdy_nxt     = 1'b0;
        release_c   = 1'b0;
        pk_fall_c   = pk_done_q & ~bus.pk_done;

        case (r_state)
            R_IDLE: begin
                if (full != 2'b00) begin
                    rd_bank_nxt = first_full;
                    r_state_nxt = R_SERVE;
                end
            end
            R_SERVE: begin
                rdy_nxt = 1'b1;
                if (pk_fall_c) begin
                    if (win_cnt == LAST_WIN) begin
                        release_c   = 1'b1;
                        win_cnt_nxt = '0;
                        rdy_nxt     = 1'b0;
                        r_state_nxt = R_IDLE;
                    end else begin
                        win_cnt_nxt = win_cnt + WCW'(1);
                    end
                end
            end
        endcase
    end

    // Read FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            rd_bank   <= 1'b0;
            win_cnt   <= '0;
            rdy_q     <= 1'b0;
            pk_done_q <= 1'b1;
        end else begin
            r_state   <= r_state_nxt;
            rd_bank   <= rd_bank_nxt;
            win_cnt   <= win_cnt_nxt;
            rdy_q     <= rdy_nxt;
            pk_done_q <= bus.pk_done;
        end
    end

    // Out-of-range addresses are folded to 0 for the RAM and zeroed on output.
    always_comb begin
        in_range_c = ({1'b0, addr_q} < LEN_EXT);
        rd_idx_c   = mem_idx(rd_bank, in_range_c ? addr_q : '0);
    end

    // Sample RAM: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (we_c && !rst) mem[mem_idx(we_bank_c, we_ptr_c)] <= bus.s_data;
        mem_q <= mem[rd_idx_c];
    end

    // Read pipeline: request reg (t), RAM (t+1), FreqOut (t+2), held when rd=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= 1'b0;
            addr_q  <= '0;
            rd_q2   <= 1'b0;
            zero_q2 <= 1'b0;
            freq_q  <= '0;
        end else begin
            rd_q    <= bus.rd;
            addr_q  <= bus.addr_in;
            rd_q2   <= rd_q;
            zero_q2 <= !in_range_c || (r_state == R_IDLE);
            if (rd_q2) freq_q <= zero_q2 ? '0 : mem_q;
        end
    end

    assign bus.rdy        = rdy_q;
    assign bus.FreqOut    = freq_q;
    assign bus.frame_drop = frame_drop_q;
    assign bus.short_err  = short_err_q;
    assign bus.ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_spectrum_frame_buffer.sv
// Directed self-checking bench for spectrum_frame_buffer (FRAME_LEN=512, 3 windows/frame).
module tb_spectrum_frame_buffer;
    localparam int unsigned FRAME_LEN = 512;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    spectrum_frame_buffer_if #(.DW(8)) bus ();

    spectrum_frame_buffer #(
        .FRAME_LEN(FRAME_LEN),
        .WINDOWS_PER_FRAME(3),
        .DW(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the active edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic sof);
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_data  = d;
        tick();
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    // Samples first..first+count-1 with value (index + off) mod 256.
    task automatic stream(input int first, input int count, input logic [7:0] off, input logic with_sof);
        for (int i = first; i < first + count; i++)
            push(8'(i + int'(off)), with_sof && (i == first));
    endtask

    task automatic read_at(input logic [11:0] a, input logic [7:0] exp, input string tag);
        bus.rd      = 1'b1;
        bus.addr_in = a;
        tick();
        bus.rd = 1'b0;
        tick();
        tick();
        check_eq(tag, 32'(bus.FreqOut), 32'(exp));
    endtask

    // Three pk_done falling edges; rdy must survive the first two and drop after the third.
    task automatic release_frame(input string tag);
        for (int k = 0; k < 2; k++) begin
            bus.pk_done = 1'b0;
            tick();
            bus.pk_done = 1'b1;
            tick();
            check_eq({tag, "_rdy_mid"}, 32'(bus.rdy), 32'h1);
        end
        bus.pk_done = 1'b0;
        tick();
        check_eq({tag, "_rdy_drop"}, 32'(bus.rdy), 32'h0);
        bus.pk_done = 1'b1;
        tick();
        check_eq({tag, "_rdy_gap"}, 32'(bus.rdy), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
        bus.rd      = 1'b0;
        bus.addr_in = '0;
        bus.pk_done = 1'b1;
        rst         = 1'b1;
        tick();
        tick();

        // 1: reset state, then one full frame value=addr[7:0]
        check_eq("rst_rdy", 32'(bus.rdy), 32'h0);
        check_eq("rst_freq", 32'(bus.FreqOut), 32'h0);
        check_eq("rst_ovf", 32'(bus.ovf_cnt), 32'h0);
        check_eq("rst_drop", 32'(bus.frame_drop), 32'h0);
        check_eq("rst_short", 32'(bus.short_err), 32'h0);
        rst = 1'b0;
        stream(0, FRAME_LEN, 8'h00, 1'b1);
        check_eq("t1_rdy_t0", 32'(bus.rdy), 32'h0);
        tick();
        check_eq("t1_rdy_t1", 32'(bus.rdy), 32'h0);
        tick();
        check_eq("t1_rdy_t2", 32'(bus.rdy), 32'h1);

        // 2: read latency, out-of-range, top address, hold
        bus.rd      = 1'b1;
        bus.addr_in = 12'd50;
        tick();
        tick();
        check_eq("t2_lat1", 32'(bus.FreqOut), 32'h0);
        tick();
        check_eq("t2_addr50", 32'(bus.FreqOut), 32'h32);
        bus.addr_in = 12'd600;
        tick(); tick(); tick();
        check_eq("t2_addr600", 32'(bus.FreqOut), 32'h0);
        bus.addr_in = 12'd511;
        tick(); tick(); tick();
        check_eq("t2_addr511", 32'(bus.FreqOut), 32'hFF);
        bus.rd      = 1'b0;
        bus.addr_in = 12'd10;
        tick(); tick(); tick(); tick();
        check_eq("t2_hold", 32'(bus.FreqOut), 32'hFF);

        // 3: window count releases the frame; reads while idle return 0
        release_frame("t3");
        read_at(12'd50, 8'h00, "t3_rd_idle");
        check_eq("t3_stay_idle", 32'(bus.rdy), 32'h0);

        // 4: two frames held, third dropped, oldest served after release
        stream(0, FRAME_LEN, 8'h10, 1'b1);
        stream(0, FRAME_LEN, 8'h20, 1'b1);
        push(8'h99, 1'b1);
        check_eq("t4_drop", 32'(bus.frame_drop), 32'h1);
        check_eq("t4_ovf1", 32'(bus.ovf_cnt), 32'h1);
        push(8'h9A, 1'b0);
        check_eq("t4_drop_pulse", 32'(bus.frame_drop), 32'h0);
        release_frame("t4a");
        tick();
        check_eq("t4_rdy_back", 32'(bus.rdy), 32'h1);
        read_at(12'd5, 8'h25, "t4_oldest");
        push(8'h30, 1'b1);
        check_eq("t4_sof_accept", 32'(bus.frame_drop), 32'h0);
        check_eq("t4_ovf_keep", 32'(bus.ovf_cnt), 32'h1);
        stream(1, FRAME_LEN - 1, 8'h30, 1'b0);
        release_frame("t4b");
        tick();
        check_eq("t4_rdy_next", 32'(bus.rdy), 32'h1);
        read_at(12'd200, 8'hF8, "t4_next_data");

        // 5: sof after 100 samples restarts the frame
        stream(0, 100, 8'h40, 1'b1);
        push(8'h50, 1'b1);
        check_eq("t5_short", 32'(bus.short_err), 32'h1);
        push(8'h51, 1'b0);
        check_eq("t5_short_pulse", 32'(bus.short_err), 32'h0);
        stream(2, FRAME_LEN - 3, 8'h50, 1'b0);
        release_frame("t5");
        tick();
        check_eq("t5_not_yet", 32'(bus.rdy), 32'h0);
        push(8'h4F, 1'b0);
        check_eq("t5_last_t0", 32'(bus.rdy), 32'h0);
        tick();
        tick();
        check_eq("t5_complete", 32'(bus.rdy), 32'h1);
        read_at(12'd0, 8'h50, "t5_addr0");
        read_at(12'd99, 8'hB3, "t5_addr99");
        read_at(12'd511, 8'h4F, "t5_addr511");

        // 6: reset while filling and serving
        stream(0, 20, 8'h60, 1'b1);
        rst = 1'b1;
        tick();
        check_eq("t6_rdy", 32'(bus.rdy), 32'h0);
        check_eq("t6_freq", 32'(bus.FreqOut), 32'h0);
        check_eq("t6_ovf", 32'(bus.ovf_cnt), 32'h0);
        rst = 1'b0;
        tick(); tick(); tick();
        check_eq("t6_banks_empty", 32'(bus.rdy), 32'h0);
        stream(0, FRAME_LEN, 8'h70, 1'b1);
        stream(0, FRAME_LEN, 8'h80, 1'b1);
        check_eq("t6_no_drop", 32'(bus.ovf_cnt), 32'h0);
        check_eq("t6_serving", 32'(bus.rdy), 32'h1);
        read_at(12'd3, 8'h73, "t6_data");
        push(8'h00, 1'b1);
        check_eq("t6_third_drop", 32'(bus.frame_drop), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
